// File: rtl/stepgen_sched.sv
`default_nettype none
// stepgen_sched: shadow/active register bank, shared step_enable prescaler and commit watchdog
// for a bank of stepgen channels. Revision 1.0
module stepgen_sched #(
  parameter int N   = 4,
  parameter int F   = 10,
  parameter int T   = 5,
  parameter int DIV = 4,
  parameter int WDW = 16,
  parameter int AW  = 3,
  parameter logic [T-1:0] DIRTIME_DEF  = 5'd10,
  parameter logic [T-1:0] STEPTIME_DEF = 5'd10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 commit,
  output logic [N*(F+1)-1:0]   velocity,
  output logic [T-1:0]         dirtime,
  output logic [T-1:0]         steptime,
  output logic                 step_enable,
  output logic                 commit_ack,
  output logic                 wd_fault,
  output logic [1:0]           state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);
  localparam logic [AW-1:0] ADDR_DIR  = AW'(N);
  localparam logic [AW-1:0] ADDR_STEP = AW'(N + 1);
  localparam logic [AW-1:0] ADDR_WD   = AW'(N + 2);

  logic [1:0]          state_q, state_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic [WDW-1:0]      wd_rl_q, wd_rl_d;
  logic [N-1:0][F:0]   vel_sh_q, vel_sh_d;
  logic [N-1:0][F:0]   vel_act_q, vel_act_d;
  logic [T-1:0]        dir_sh_q, dir_sh_d, dir_act_q, dir_act_d;
  logic [T-1:0]        step_sh_q, step_sh_d, step_act_q, step_act_d;
  logic                se_q, se_d;
  logic                ack_q, ack_d;
  logic                w_tick;
  logic                w_unused_data;

  assign w_unused_data = ^wr_data;
  assign w_tick = ((state_q == S_RUN) || (state_q == S_FAULT)) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    wd_d       = wd_q;
    wd_rl_d    = wd_rl_q;
    vel_sh_d   = vel_sh_q;
    vel_act_d  = vel_act_q;
    dir_sh_d   = dir_sh_q;
    dir_act_d  = dir_act_q;
    step_sh_d  = step_sh_q;
    step_act_d = step_act_q;
    se_d       = w_tick;
    ack_d      = 1'b0;

    // Shadow writes land in _d only; a same-cycle load still copies the _q values.
    if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (wr_addr == AW'(i)) vel_sh_d[i] = wr_data[F:0];
      end
      if (wr_addr == ADDR_DIR)  dir_sh_d  = wr_data[T-1:0];
      if (wr_addr == ADDR_STEP) step_sh_d = wr_data[T-1:0];
      if (wr_addr == ADDR_WD)   wd_rl_d   = wr_data[WDW-1:0];
    end

    if (!arm) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pend_d    = 1'b0;
      vel_act_d = '0;
      se_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          wd_d    = wd_rl_q;
        end
        S_RUN: begin
          cnt_d = w_tick ? '0 : cnt_q + 1'b1;
          if (w_tick && pend_q) begin
            vel_act_d  = vel_sh_q;
            dir_act_d  = dir_sh_q;
            step_act_d = step_sh_q;
            pend_d     = commit;
            wd_d       = wd_rl_q;
            ack_d      = 1'b1;
          end else begin
            if (commit) pend_d = 1'b1;
            if (w_tick && (wd_rl_q != '0) && (wd_q != '0)) begin
              wd_d = wd_q - 1'b1;
              if (wd_q == WDW'(1)) begin
                state_d   = S_FAULT;
                vel_act_d = '0;
                pend_d    = 1'b0;
              end
            end
          end
        end
        S_FAULT: begin
          cnt_d     = w_tick ? '0 : cnt_q + 1'b1;
          pend_d    = 1'b0;
          vel_act_d = '0;
        end
        default: begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          pend_d    = 1'b0;
          vel_act_d = '0;
          se_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      wd_q       <= '0;
      wd_rl_q    <= '0;
      vel_sh_q   <= '0;
      vel_act_q  <= '0;
      dir_sh_q   <= DIRTIME_DEF;
      dir_act_q  <= DIRTIME_DEF;
      step_sh_q  <= STEPTIME_DEF;
      step_act_q <= STEPTIME_DEF;
      se_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      wd_q       <= wd_d;
      wd_rl_q    <= wd_rl_d;
      vel_sh_q   <= vel_sh_d;
      vel_act_q  <= vel_act_d;
      dir_sh_q   <= dir_sh_d;
      dir_act_q  <= dir_act_d;
      step_sh_q  <= step_sh_d;
      step_act_q <= step_act_d;
      se_q       <= se_d;
      ack_q      <= ack_d;
    end
  end

  assign velocity    = vel_act_q;
  assign dirtime     = dir_act_q;
  assign steptime    = step_act_q;
  assign step_enable = se_q;
  assign commit_ack  = ack_q;
  assign wd_fault    = (state_q == S_FAULT);
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stepgen_sched.sv
`default_nettype none
// tb_stepgen_sched: scoreboard bench; each commit pushes the expected active set, each ack pops it.
// Revision 1.0
module tb_stepgen_sched;

  localparam int N  = 4;
  localparam int F  = 10;
  localparam int T  = 5;
  localparam int VW = N * (F + 1);

  typedef struct packed {
    logic [VW-1:0] vel;
    logic [T-1:0]  dir;
    logic [T-1:0]  step;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic [VW-1:0] velocity;
  logic [T-1:0]  dirtime, steptime;
  logic          step_enable, commit_ack, wd_fault;
  logic [1:0]    state;

  stepgen_sched dut (
    .clk(clk), .reset(reset), .arm(arm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .velocity(velocity), .dirtime(dirtime),
    .steptime(steptime), .step_enable(step_enable), .commit_ack(commit_ack),
    .wd_fault(wd_fault), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [F:0]    sh_vel [N];
  logic [T-1:0]  sh_dir, sh_step;
  logic [VW-1:0] act_vel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] pack_sh();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*(F+1) +: F+1] = sh_vel[i];
    return r;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.vel  = pack_sh();
    e.dir  = sh_dir;
    e.step = sh_step;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) sh_vel[i] = '0;
    sh_dir  = 5'd10;
    sh_step = 5'd10;
    act_vel = '0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (reset && commit_ack) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        check("ack_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_velocity", 64'(velocity), 64'(mon_e.vel));
        check("sb_dirtime", 64'(dirtime), 64'(mon_e.dir));
        check("sb_steptime", 64'(steptime), 64'(mon_e.step));
        check("sb_step_enable", 64'(step_enable), 64'd1);
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 3'(N)) sh_vel[a] = d[F:0];
    else if (a == 3'(N))     sh_dir  = d[T-1:0];
    else if (a == 3'(N + 1)) sh_step = d[T-1:0];
  endtask

  task automatic commit_and_wait(input int budget);
    exp_t e;
    logic got, pre_ok;
    logic [VW-1:0] old;
    e = cur_exp();
    sb.push_back(e);
    old = act_vel; got = 1'b0; pre_ok = 1'b1;
    commit = 1'b1;
    for (int k = 1; k <= budget && !got; k++) begin
      @(negedge clk);
      commit = 1'b0;
      if (commit_ack) got = 1'b1;
      else if (velocity !== old) pre_ok = 1'b0;
    end
    commit = 1'b0;
    check("ack_within_budget", 64'(got), 64'd1);
    check("vel_held_before_ack", 64'(pre_ok), 64'd1);
    if (got) act_vel = e.vel;
    else sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int pulses, acks0;
    logic found;
    model_reset();

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_velocity", 64'(velocity), 64'd0);
    check("rst_dirtime", 64'(dirtime), 64'd10);
    check("rst_steptime", 64'(steptime), 64'd10);
    check("rst_state", 64'(state), 64'd0);
    check("rst_flags", {61'd0, step_enable, commit_ack, wd_fault}, 64'd0);

    // 1: reset mid-operation
    reset = 1'b1; arm = 1'b1;
    @(negedge clk);
    check("arm_to_run", 64'(state), 64'd1);
    wr(3'd0, 32'h010);
    wr(3'd4, 32'd7);
    commit_and_wait(5);
    check("t1_dirtime_applied", 64'(dirtime), 64'd7);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t1_async_velocity", 64'(velocity), 64'd0);
    check("t1_async_dirtime", 64'(dirtime), 64'd10);
    check("t1_async_state", 64'(state), 64'd0);
    check("t1_async_flags", {61'd0, step_enable, commit_ack, wd_fault}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 2: atomic commit
    wr(3'd0, 32'h001); wr(3'd1, 32'h402); wr(3'd2, 32'h7FF); wr(3'd3, 32'hFFFF_F100);
    commit_and_wait(5);
    check("t2_state_run", 64'(state), 64'd1);

    // 3: write on the load cycle misses that load
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (step_enable) found = 1'b1;
    end
    check("t3_sync_step_enable", 64'(found), 64'd1);
    e = cur_exp();
    sb.push_back(e);
    commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h055;
    @(negedge clk);
    wr_en = 1'b0; sh_vel[1] = 11'h055;
    check("t3_collision_ack", 64'(commit_ack), 64'd1);
    check("t3_old_v1_kept", 64'(velocity[11 +: 11]), 64'h402);
    act_vel = e.vel;
    commit_and_wait(5);
    check("t3_new_v1", 64'(velocity[11 +: 11]), 64'h055);

    // 4: watchdog expiry
    wr(3'd6, 32'd3);
    commit_and_wait(5);
    repeat (11) @(negedge clk);
    check("t4_still_run", 64'(state), 64'd1);
    @(negedge clk);
    act_vel = '0;
    check("t4_fault_state", 64'(state), 64'd2);
    check("t4_wd_fault", 64'(wd_fault), 64'd1);
    check("t4_vel_zero", 64'(velocity), 64'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (step_enable) pulses++;
    end
    check("t4_fault_ticks", 64'(pulses), 64'd2);
    acks0 = ack_cnt;
    commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_no_ack_in_fault", 64'(ack_cnt), 64'(acks0));
    check("t4_fault_holds", 64'(state), 64'd2);

    // 5: recovery through IDLE
    wr(3'd6, 32'd0);
    arm = 1'b0;
    @(negedge clk);
    check("t5_idle", 64'(state), 64'd0);
    check("t5_fault_clear", 64'(wd_fault), 64'd0);
    check("t5_se_clear", 64'(step_enable), 64'd0);
    arm = 1'b1;
    @(negedge clk);
    check("t5_rerun", 64'(state), 64'd1);
    wr(3'd0, 32'h123); wr(3'd2, 32'h456);
    commit_and_wait(5);
    repeat (4000) @(negedge clk);
    check("t5_no_fault_state", 64'(state), 64'd1);
    check("t5_no_fault_flag", 64'(wd_fault), 64'd0);

    // 6: load on the expiry tick wins
    wr(3'd6, 32'd2);
    commit_and_wait(5);
    wr(3'd3, 32'h3AA);
    repeat (3) @(negedge clk);
    e = cur_exp();
    sb.push_back(e);
    commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_race_ack", 64'(commit_ack), 64'd1);
    check("t6_race_run", 64'(state), 64'd1);
    act_vel = e.vel;
    repeat (4) @(negedge clk);
    check("t6_reload_run", 64'(state), 64'd1);
    repeat (4) @(negedge clk);
    check("t6_reload_expiry", 64'(state), 64'd2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stepgen_sched.md
Name: stepgen_sched

Overview:
- Host-side controller for a bank of N stepgen channels.
- Holds shadow velocity and timing registers written by the host bus.
- Commits all shadows atomically on an enable-tick boundary and generates the shared step_enable prescaler tick.
- Runs a tick-based watchdog that forces all velocities to zero if the host stops committing.

Parameters:
- N, 4: number of stepgen channels.
- F, 10: velocity fraction width; each velocity is F+1 bits, with bit F as the direction.
- T, 5: dirtime/steptime width.
- DIV, 4: clk cycles per step_enable tick; must be at least 2.
- WDW, 16: watchdog counter width.
- AW, 3: write address width; must satisfy 2^AW >= N+3.
- DIRTIME_DEF, 5'd10: reset value of dirtime.
- STEPTIME_DEF, 5'd10: reset value of steptime.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  level; high = run, low = idle.
- wr_en  in  1  shadow write strobe.
- wr_addr  in  AW  0..N-1 = velocity[i], N = dirtime, N+1 = steptime, N+2 = watchdog reload; other addresses ignored.
- wr_data  in  32  write data; low bits used, extra bits ignored.
- commit  in  1  single-cycle request to apply the shadows.
- velocity  out  N*(F+1)  active velocities; channel i occupies bits [i*(F+1) +: F+1].
- dirtime  out  T  active dirtime.
- steptime  out  T  active steptime.
- step_enable  out  1  one-cycle tick, shared by all stepgens.
- commit_ack  out  1  one-cycle pulse when the shadows are applied.
- wd_fault  out  1  watchdog fault flag.
- state  out  2  current state.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; prescaler = 0; pending = 0; watchdog count = 0.
  - All shadow and active velocities = 0; dirtime/steptime (shadow and active) = their _DEF values; watchdog reload = 0.
  - step_enable, commit_ack, wd_fault = 0.
- States:
  - IDLE = 0, RUN = 1, FAULT = 2; encoding 3 is unused and recovers to IDLE.
- Prescaler:
  - Counts 0..DIV-1 while state != IDLE and is held at 0 in IDLE.
  - Internal tick = (count == DIV-1). step_enable is a registered copy of tick, so it is high for one cycle every DIV cycles.
- Shadow writes:
  - Accepted in every state whenever wr_en is high and the address is valid.
  - Velocity takes wr_data[F:0]; timing registers take [T-1:0]; watchdog reload takes [WDW-1:0].
- Commit:
  - A commit pulse sets pending (only in RUN). A commit while pending is already set is absorbed.
  - When tick && pending in RUN, the next clk edge does all of the following:
    - copies every shadow register to its active register;
    - clears pending;
    - reloads the watchdog count from the watchdog reload value;
    - asserts commit_ack for one cycle, coincident with step_enable.
  - Net effect: stepgens always see new values starting on an enable cycle.
- Simultaneous events:
  - Commit on the load cycle re-arms pending for the next tick.
  - A shadow write on the load cycle is not included; the load uses the pre-write value.
- Watchdog:
  - Active only when reload != 0.
  - In RUN, each tick that does not load decrements the count, saturating at 0.
  - Decrementing from 1 to 0 moves the block to FAULT.
  - Load and expiry on the same tick: load wins.
- FAULT:
  - All active velocities are forced to 0; dirtime/steptime are retained.
  - step_enable keeps ticking so the stepgens can finish in-flight pulses.
  - wd_fault = 1; commit requests are ignored and pending is cleared.
- Transitions:
  - IDLE -> RUN when arm = 1. Active velocities stay at 0 until the first commit; the watchdog count loads from the reload value on entry.
  - Any state -> IDLE when arm = 0, effective on the next edge. That edge also zeroes active velocities, clears pending and wd_fault, and clears step_enable. Shadows are retained.
  - FAULT is left only through IDLE.
- Latency:
  - Commit to application: at most DIV+1 cycles.
  - arm low to velocity = 0: 1 cycle.

Test Plan:
1. Reset mid-operation: release reset, arm = 1, commit v0 = 0x010; assert reset while RUN → all outputs read 0 with no clk edge, dirtime = 10.
2. Atomic commit: N=4, DIV=4; write v0..v3 = 0x001, 0x402, 0x7FF, 0x100, then commit → all four active values change on the same cycle, which has step_enable = commit_ack = 1, within 5 cycles of commit.
3. Write/commit collision: write v1 = 0x055 on the load cycle → the active value keeps the old v1; after a second commit it becomes 0x055.
4. Watchdog: reload = 3 with no further commits → FAULT after 3 ticks; velocities read 0, wd_fault = 1, step_enable still pulses every 4 cycles; a commit in FAULT produces no ack.
5. Recovery: from FAULT drop arm for 1 cycle → IDLE with wd_fault = 0; re-arm and commit → RUN with new velocities; reload = 0 → no fault after 1000 ticks.
6. Commit/expiry race: with reload = 2, issue the commit so it loads on the expiry tick → stays in RUN, count reloaded to 2, commit_ack = 1.
